// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state type, radix-4 Booth triplet codes and the
// partial-product operation select used by booth_r4_seq_mul.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Multiplier triplet {b[2i+1], b[2i], b[2i-1]} encodings
  localparam logic [2:0] SHIFT0  = 3'b000;
  localparam logic [2:0] PL_ONE0 = 3'b001;
  localparam logic [2:0] PL_ONE1 = 3'b010;
  localparam logic [2:0] PL_TWO  = 3'b011;
  localparam logic [2:0] MI_TWO  = 3'b100;
  localparam logic [2:0] MI_ONE0 = 3'b101;
  localparam logic [2:0] MI_ONE1 = 3'b110;
  localparam logic [2:0] SHIFT1  = 3'b111;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_op_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: combinational radix-4 Booth recoder, triplet -> op select.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output booth_op_t  op
);

  // Recode the current multiplier triplet into a 0/+-A/+-2A operation
  always_comb begin
    op = ZERO;
    case (triplet)
      SHIFT0, SHIFT1:   op = ZERO;
      PL_ONE0, PL_ONE1: op = P1;
      PL_TWO:           op = P2;
      MI_TWO:           op = M2;
      MI_ONE0, MI_ONE1: op = M1;
      default:          op = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// booth_r4_seq_mul: iterative radix-4 Booth multiplier, one triplet per clock.
// Optional macro BOOTH_UNSIGNED_EN adds the is_signed port (unsigned support,
// W/2+1 iterations for every operation); otherwise always signed, W/2 iterations.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           clear,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           is_signed,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
);

`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned N = W / 2 + 1;
`else
  localparam int unsigned N = W / 2;
`endif
  // Accumulator half, multiplier field (2 bits per iteration), full P register
  localparam int unsigned AW = W + 2;
  localparam int unsigned BW = 2 * N;
  localparam int unsigned PW = AW + BW + 1;

  if ((W % 2) != 0 || W < 4) begin : g_bad_width
    $error("booth_r4_seq_mul: W must be even and >= 4");
  end

  logic          ext_a;
  logic          ext_b;
  logic [AW-1:0] a_ext;
  logic [BW-1:0] b_ext;

  state_t         state_q;
  logic [AW-1:0]  a_q;
  logic [PW-1:0]  p_q;
  logic [CNT_W-1:0] cnt_q;

  booth_op_t      op;
  logic [AW-1:0]  addend;
  logic           sub;
  logic [AW-1:0]  upper_sum;
  logic [PW-1:0]  p_step;

`ifdef BOOTH_UNSIGNED_EN
  assign ext_a = is_signed & multiplicand[W-1];
  assign ext_b = is_signed & multiplier[W-1];
`else
  assign ext_a = multiplicand[W-1];
  assign ext_b = multiplier[W-1];
`endif

  // Sign/zero-extend operands to their working widths
  always_comb begin
    a_ext          = {AW{ext_a}};
    a_ext[W-1:0]   = multiplicand;
    b_ext          = {BW{ext_b}};
    b_ext[W-1:0]   = multiplier;
  end

  booth_r4_encoder u_encoder (
    .triplet (p_q[2:0]),
    .op      (op)
  );

  // Single shared add/sub on the upper half, then arithmetic shift right by 2
  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case (op)
      P1:      addend = a_q;
      P2:      addend = a_q << 1;
      M1:      begin addend = a_q;      sub = 1'b1; end
      M2:      begin addend = a_q << 1; sub = 1'b1; end
      default: ;
    endcase
    // Negation as ~X + 1 with the +1 folded into the adder carry-in;
    // (~A+1)<<1 equals ~(A<<1)+1 modulo 2**AW.
    upper_sum = p_q[PW-1 -: AW] + (addend ^ {AW{sub}}) + {{(AW-1){1'b0}}, sub};
    p_step    = {{2{upper_sum[AW-1]}}, upper_sum, p_q[PW-AW-1:2]};
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a_ext;
            p_q     <= {{AW{1'b0}}, b_ext, 1'b0};
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          done  <= 1'b0;
          p_q   <= p_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            busy    <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          result <= p_q[2*W:1];
          done   <= 1'b1;
          if (start) begin
            a_q     <= a_ext;
            p_q     <= {{AW{1'b0}}, b_ext, 1'b0};
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// tb_booth_r4_seq_mul: table-driven, directed and random checks of
// booth_r4_seq_mul (W=64) against a plain-arithmetic product model.
module tb_booth_r4_seq_mul;

  localparam int unsigned W = 64;
`ifdef BOOTH_UNSIGNED_EN
  localparam int unsigned N = W / 2 + 1;
`else
  localparam int unsigned N = W / 2;
`endif
  localparam int unsigned LAT   = N + 1;
  localparam int unsigned NRAND = 400;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           clear;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
`ifdef BOOTH_UNSIGNED_EN
  logic           is_signed;
`endif
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  booth_r4_seq_mul #(.W(W), .CNT_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .clear        (clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed    (is_signed),
`endif
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Reference: extend to 2W bits, multiply, keep low 2W bits
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit sgn);
    logic [2*W-1:0] ae;
    logic [2*W-1:0] be;
    ae = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    be = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ae * be;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    multiplicand = a;
    multiplier   = b;
`ifdef BOOTH_UNSIGNED_EN
    is_signed    = sgn;
`endif
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Wait (bounded) for done, scrambling operands meanwhile; check latency
  task automatic wait_done(input string name);
    int unsigned lat;
    lat = 0;
    for (int unsigned i = 1; i <= LAT + 8; i++) begin
      multiplicand = {$urandom(), $urandom()};
      multiplier   = {$urandom(), $urandom()};
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check($sformatf("%s latency", name), 128'(lat), 128'(LAT));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sgn, input logic [2*W-1:0] exp);
    launch(a, b, sgn);
    check($sformatf("%s busy", name), 128'(busy), 128'd1);
    wait_done(name);
    check($sformatf("%s result", name), result, exp);
    tick();
    check($sformatf("%s done width", name), 128'(done), 128'd0);
  endtask

  initial begin
    int unsigned bc;
    int unsigned dc;
    int unsigned first;
    bit          s;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs.push_back('{64'd3, 64'd5, 1'b1, 128'd15});
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 128'd1});
    vecs.push_back('{64'h8000000000000000, 64'h8000000000000000, 1'b1,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000});
    vecs.push_back('{64'h8000000000000000, 64'd1, 1'b1,
                     128'hFFFFFFFFFFFFFFFF_8000000000000000});
    vecs.push_back('{64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1'b1,
                     128'h3FFFFFFFFFFFFFFF_0000000000000001});
    vecs.push_back('{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b1,
                     128'h0000000000000000_8000000000000000});
    vecs.push_back('{64'd3, 64'hFFFFFFFFFFFFFFFB, 1'b1,
                     128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFF1});
    vecs.push_back('{64'd0, 64'h123456789ABCDEF0, 1'b1, 128'd0});
    vecs.push_back('{64'h5555555555555555, 64'd2, 1'b1,
                     128'h0000000000000000_AAAAAAAAAAAAAAAA});
`ifdef BOOTH_UNSIGNED_EN
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0,
                     128'hFFFFFFFFFFFFFFFE_0000000000000001});
    vecs.push_back('{64'h8000000000000000, 64'd2, 1'b0,
                     128'h0000000000000001_0000000000000000});
    vecs.push_back('{64'd3, 64'd5, 1'b0, 128'd15});
`endif

    reset_n      = 1'b0;
    start        = 1'b0;
    clear        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
`ifdef BOOTH_UNSIGNED_EN
    is_signed    = 1'b1;
`endif
    tick();
    tick();
    check("reset busy", 128'(busy), 128'd0);
    check("reset done", 128'(done), 128'd0);
    check("reset result", result, 128'd0);
    reset_n = 1'b1;
    tick();

    // Busy window, single done pulse and its position
    launch(64'd3, 64'd5, 1'b1);
    bc = busy ? 1 : 0;
    dc = 0;
    first = 0;
    for (int unsigned i = 1; i <= LAT + 3; i++) begin
      tick();
      if (busy) bc++;
      if (done) begin
        dc++;
        if (first == 0) first = i;
      end
    end
    check("t1 busy cycles", 128'(bc), 128'(N));
    check("t1 done count", 128'(dc), 128'd1);
    check("t1 done edge", 128'(first), 128'(LAT));
    check("t1 result held", result, 128'd15);

    // Table vectors
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);

    // Start re-pulsed mid-operation is ignored
    launch(64'd3, 64'd5, 1'b1);
    dc = 0;
    first = 0;
    for (int unsigned i = 1; i <= LAT + 14; i++) begin
      if (i == 10) begin
        start = 1'b1; multiplicand = 64'd7; multiplier = 64'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        dc++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    check("t3 done edge", 128'(first), 128'(LAT));
    check("t3 done count", 128'(dc), 128'd1);
    check("t3 result", result, 128'd15);

    // Async reset mid-operation
    launch(64'd9, 64'd9, 1'b1);
    for (int unsigned i = 0; i < 11; i++) tick();
    reset_n = 1'b0;
    #1;
    check("t4 busy", 128'(busy), 128'd0);
    check("t4 done", 128'(done), 128'd0);
    check("t4 result", result, 128'd0);
    tick();
    reset_n = 1'b1;
    dc = 0;
    for (int unsigned i = 0; i < LAT + 5; i++) begin
      tick();
      if (done) dc++;
    end
    check("t4 no pulse", 128'(dc), 128'd0);

    // Synchronous clear keeps the previous result
    run_op("t5 pre", 64'd3, 64'd5, 1'b1, 128'd15);
    launch(64'd7, 64'd7, 1'b1);
    for (int unsigned i = 0; i < 19; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5 busy", 128'(busy), 128'd0);
    check("t5 done", 128'(done), 128'd0);
    check("t5 result kept", result, 128'd15);
    dc = 0;
    for (int unsigned i = 0; i < LAT + 3; i++) begin
      tick();
      if (done) dc++;
    end
    check("t5 no pulse", 128'(dc), 128'd0);
    run_op("t5 post", 64'd9, 64'd9, 1'b1, 128'd81);

    // Back-to-back: start accepted in the DONE cycle
    launch(64'd11, 64'd13, 1'b1);
    first = 0;
    for (int unsigned i = 1; i <= LAT + 4; i++) begin
      tick();
      if (!busy) begin
        first = i;
        break;
      end
    end
    check("b2b busy drop", 128'(first), 128'(N));
    launch(64'd6, 64'hFFFFFFFFFFFFFFF9, 1'b1);
    check("b2b first done", 128'(done), 128'd1);
    check("b2b first result", result, 128'd143);
    check("b2b busy", 128'(busy), 128'd1);
    wait_done("b2b second");
    check("b2b second result", result, ref_mul(64'd6, 64'hFFFFFFFFFFFFFFF9, 1'b1));
    tick();

    // Random operands against the arithmetic model
    for (int unsigned n = 0; n < NRAND; n++) begin
      ra = rand_op();
      rb = rand_op();
`ifdef BOOTH_UNSIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b1;
`endif
      run_op($sformatf("rand%0d", n), ra, rb, s, ref_mul(ra, rb, s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
